// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath width, mul/div op encodings
// and the FSM state type for the sequential multiply/divide unit.
package cpu_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/nr_div_step.sv
// One non-restoring division iteration on magnitudes.
// The partial remainder is signed, one bit wider than the operands.
module nr_div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_next,
  output logic [W-1:0] quo_next
);

  logic [W:0] shifted;

  // Shift the next dividend bit in, then subtract or add back depending on
  // the sign left by the previous step.
  assign shifted  = {rem[W-1:0], quo[W-1]};
  assign rem_next = rem[W] ? shifted + {1'b0, divisor} : shifted - {1'b0, divisor};
  assign quo_next = {quo[W-2:0], ~rem_next[W]};

endmodule

// File: rtl/mul_div_unit.sv
// Sequential signed multiplier (radix-2 Booth) with an optional signed
// non-restoring divider, compiled only when MUL_DIV_DIVIDER_EN is defined.
module mul_div_unit
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] zhi,
  output logic [DATA_WIDTH-1:0] zlo,
  output logic                  div_zero
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(W);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [W:0]       acc;
  logic [W-1:0]     q;
  logic [W-1:0]     m;
  logic             q_1;
  logic             skip;

  // Booth accumulator carries one guard bit so -m of the most-negative
  // multiplicand does not overflow.
  logic [W:0]   m_ext;
  logic [W:0]   booth_sum;
  logic [W:0]   booth_acc_next;
  logic [W-1:0] booth_q_next;

  assign m_ext = {m[W-1], m};

  always_comb begin
    booth_sum = acc;
    case ({q[0], q_1})
      2'b01:   booth_sum = acc + m_ext;
      2'b10:   booth_sum = acc - m_ext;
      default: booth_sum = acc;
    endcase
  end

  assign booth_acc_next = {booth_sum[W], booth_sum[W:1]};
  assign booth_q_next   = {booth_sum[0], q[W-1:1]};

`ifdef MUL_DIV_DIVIDER_EN
  logic         op_reg;
  logic         neg_q;
  logic         neg_r;
  logic [W-1:0] a_mag;
  logic [W-1:0] b_mag;
  logic [W:0]   rem_next;
  logic [W-1:0] quo_next;
  logic [W-1:0] rem_fix;
  logic [W-1:0] div_q;
  logic [W-1:0] div_r;

  assign a_mag = a[W-1] ? -a : a;
  assign b_mag = b[W-1] ? -b : b;

  nr_div_step #(.W(W)) u_step (
    .rem      (acc),
    .quo      (q),
    .divisor  (m),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Quotient sign follows the operand signs, remainder sign follows the dividend.
  assign rem_fix = rem_next[W] ? rem_next[W-1:0] + m : rem_next[W-1:0];
  assign div_q   = neg_q ? -quo_next : quo_next;
  assign div_r   = neg_r ? -rem_fix : rem_fix;
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      zhi      <= '0;
      zlo      <= '0;
      div_zero <= 1'b0;
      count    <= '0;
      acc      <= '0;
      q        <= '0;
      m        <= '0;
      q_1      <= 1'b0;
      skip     <= 1'b0;
`ifdef MUL_DIV_DIVIDER_EN
      op_reg   <= OP_MUL;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            count <= CNT_W'(W - 1);
            acc   <= '0;
            q_1   <= 1'b0;
            m     <= a;
            q     <= b;
            skip  <= (op == OP_DIV);
`ifdef MUL_DIV_DIVIDER_EN
            op_reg <= op;
            if (op == OP_DIV) begin
              // A zero divisor keeps the raw dividend in m for the remainder output.
              skip  <= (b == '0);
              m     <= (b == '0) ? a : b_mag;
              q     <= a_mag;
              neg_q <= a[W-1] ^ b[W-1];
              neg_r <= a[W-1];
            end
`endif
          end
        end

        RUN: begin
          if (skip) begin
            // No iterations: result is known at accept, finish on the next edge.
            state <= DONE;
            done  <= 1'b1;
            zlo   <= '0;
`ifdef MUL_DIV_DIVIDER_EN
            zhi      <= m;
            div_zero <= 1'b1;
`else
            zhi      <= '0;
            div_zero <= 1'b0;
`endif
          end else begin
            count <= count - 1'b1;
`ifdef MUL_DIV_DIVIDER_EN
            if (op_reg == OP_DIV) begin
              acc <= rem_next;
              q   <= quo_next;
            end else
`endif
            begin
              acc <= booth_acc_next;
              q   <= booth_q_next;
              q_1 <= q[0];
            end
            if (count == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              div_zero <= 1'b0;
`ifdef MUL_DIV_DIVIDER_EN
              if (op_reg == OP_DIV) begin
                zhi <= div_r;
                zlo <= div_q;
              end else
`endif
              begin
                zhi <= booth_acc_next[W-1:0];
                zlo <= booth_q_next;
              end
            end
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit; expectations for op=1 follow
// whether MUL_DIV_DIVIDER_EN is defined for the build.
module tb_mul_div_unit;

`ifdef MUL_DIV_DIVIDER_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clock;
  logic        clear;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] zhi;
  logic [31:0] zlo;
  logic        div_zero;

  int errors = 0;
  int checks = 0;

  mul_div_unit #(.DATA_WIDTH(32)) dut (
    .clock    (clock),
    .clear    (clear),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .zhi      (zhi),
    .zlo      (zlo),
    .div_zero (div_zero)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Latency is the index of the edge after accept at which done is sampled high.
  task automatic run_op(input string tag, input logic opv,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input int elat, input int inject_at);
    int lat;
    lat = 0;
    @(negedge clock);
    start = 1'b1;
    op    = opv;
    a     = av;
    b     = bv;
    @(posedge clock);
    #1;
    start = 1'b0;
    check({tag, " busy"}, 32'(busy), 32'd1);
    for (int k = 1; k <= 80; k++) begin
      if (k > 1) begin
        @(posedge clock);
        #1;
      end
      if (done) begin
        lat = k;
        break;
      end
      start = (k == inject_at);
      if (k == inject_at) begin
        op = ~opv;
        a  = 32'h0000_0064;
        b  = 32'h0000_0007;
      end
    end
    start = 1'b0;
    check({tag, " done_seen"}, 32'(lat != 0), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(elat));
    check({tag, " zhi"}, zhi, ehi);
    check({tag, " zlo"}, zlo, elo);
    check({tag, " div_zero"}, 32'(div_zero), 32'(edz));
    $display("%s: op=%0d a=%h b=%h -> zhi=%h zlo=%h div_zero=%b latency=%0d",
             tag, opv, av, bv, zhi, zlo, div_zero, lat);
    @(posedge clock);
    #1;
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " busy_idle"}, 32'(busy), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    check({tag, " zhi_hold"}, zhi, ehi);
  endtask

  initial begin
    int  lat_div;
    bit  saw_done;
    lat_div = DIV_EN ? 33 : 2;

    clear = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset zhi", zhi, 32'd0);
    check("reset zlo", zlo, 32'd0);
    check("reset div_zero", 32'(div_zero), 32'd0);
    @(negedge clock);
    clear = 1'b0;

    run_op("mul 7*-3", 1'b0, 32'd7, 32'hFFFF_FFFD,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 0);
    run_op("mul minneg^2", 1'b0, 32'h8000_0000, 32'h8000_0000,
           32'h4000_0000, 32'h0000_0000, 1'b0, 33, 0);
    run_op("mul -1*-1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'h0000_0000, 32'h0000_0001, 1'b0, 33, 0);
    run_op("mul 12345*0", 1'b0, 32'h0000_3039, 32'h0000_0000,
           32'h0000_0000, 32'h0000_0000, 1'b0, 33, 0);
    run_op("div 17/-5", 1'b1, 32'd17, 32'hFFFF_FFFB,
           DIV_EN ? 32'h0000_0002 : 32'h0, DIV_EN ? 32'hFFFF_FFFD : 32'h0, 1'b0, lat_div, 0);
    run_op("div -17/5", 1'b1, 32'hFFFF_FFEF, 32'd5,
           DIV_EN ? 32'hFFFF_FFFE : 32'h0, DIV_EN ? 32'hFFFF_FFFD : 32'h0, 1'b0, lat_div, 0);
    run_op("div 5/0", 1'b1, 32'd5, 32'd0,
           DIV_EN ? 32'h0000_0005 : 32'h0, 32'h0, DIV_EN, 2, 0);
    run_op("div minneg/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0, DIV_EN ? 32'h8000_0000 : 32'h0, 1'b0, lat_div, 0);
    run_op("div 100/7", 1'b1, 32'd100, 32'd7,
           DIV_EN ? 32'h0000_0002 : 32'h0, DIV_EN ? 32'h0000_000E : 32'h0, 1'b0, lat_div, 0);
    run_op("mul 7*-3 start@5", 1'b0, 32'd7, 32'hFFFF_FFFD,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 5);

    // Clear in the middle of a multiply must zero everything without a clock edge.
    @(negedge clock);
    start = 1'b1;
    op    = 1'b0;
    a     = 32'h8000_0000;
    b     = 32'h0000_0003;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    check("preclear busy", 32'(busy), 32'd1);
    check("preclear zlo", zlo, 32'hFFFF_FFEB);
    #1;
    clear = 1'b1;
    #1;
    check("clear busy", 32'(busy), 32'd0);
    check("clear zhi", zhi, 32'd0);
    check("clear zlo", zlo, 32'd0);
    check("clear done", 32'(done), 32'd0);
    @(negedge clock);
    clear = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      if (done) saw_done = 1'b1;
    end
    check("clear no_done", 32'(saw_done), 32'd0);
    check("clear busy_after", 32'(busy), 32'd0);
    $display("clear mid-mul: busy=%b zhi=%h zlo=%h done_after=%b", busy, zhi, zlo, saw_done);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
